// File: rtl/popcount_pkg.sv
// Shared helpers for the pipelined population counter: group count, tree sizing, level widths.
package popcount_pkg;

    localparam int MAX_LVL = 16;

    typedef logic [MAX_LVL:0] stage_vld_t;

    function automatic logic [2:0] grp_cnt4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

    function automatic int calc_groups(input int width);
        return (width + 3) / 4;
    endfunction

    function automatic int calc_levels(input int groups);
        return (groups <= 1) ? 0 : $clog2(groups);
    endfunction

    // Each adder level grows the partial sums by exactly one bit.
    function automatic int lvl_w(input int lvl);
        return 3 + lvl;
    endfunction

    function automatic int lvl_n(input int groups, input int lvl);
        return (groups + (1 << lvl) - 1) >> lvl;
    endfunction

endpackage

// File: rtl/popcount_level.sv
// One registered pairwise-add level of the popcount tree; an odd trailing element passes through.
module popcount_level #(
    parameter int  N_IN    = 2,
    parameter int  IN_W    = 3,
    parameter bit  LAST_EN = 1'b0,
    localparam int N_OUT   = (N_IN + 1) / 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic                         in_vld,
    input  logic                         in_last,
    input  logic [N_IN-1:0][IN_W-1:0]    in_cnt,
    output logic                         out_vld,
    output logic                         out_last,
    output logic [N_OUT-1:0][IN_W:0]     out_cnt
);

    logic [2*N_OUT-1:0][IN_W-1:0] pad;
    logic [N_OUT-1:0][IN_W:0]     cnt_d, cnt_q;
    logic                         vld_d, vld_q;

    always_comb begin
        pad = '0;
        pad[N_IN-1:0] = in_cnt;
        vld_d = en ? in_vld : vld_q;
        cnt_d = cnt_q;
        // Data only loads with a real beat so idle inputs never disturb the registers.
        if (en & in_vld) begin
            for (int i = 0; i < N_OUT; i++)
                cnt_d[i] = {1'b0, pad[2*i]} + {1'b0, pad[2*i+1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            vld_q <= vld_d;
            cnt_q <= cnt_d;
        end
    end

    if (LAST_EN) begin : g_last
        logic last_d, last_q;
        always_comb last_d = (en & in_vld) ? in_last : last_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) last_q <= 1'b0;
            else        last_q <= last_d;
        end
        assign out_last = last_q;
    end else begin : g_nolast
        logic unused_last;
        assign unused_last = in_last;
        assign out_last    = 1'b0;
    end

    assign out_vld = vld_q;
    assign out_cnt = cnt_q;

endmodule

// File: rtl/popcount_pipe.sv
// Pipelined WIDTH-bit population counter with valid/ready flow control.
// Define POPCOUNT_ACCUM_EN to add the saturating per-frame accumulator.
module popcount_pipe
    import popcount_pkg::*;
#(
    parameter int  WIDTH = 16,
    parameter int  ACC_W = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    input  logic             acc_clr,
    output logic             acc_valid,
    output logic [ACC_W-1:0] acc_total
);

    localparam int GROUPS = calc_groups(WIDTH);
    localparam int L      = calc_levels(GROUPS);
    localparam int PAD_W  = 4 * GROUPS;
    localparam int FIN_W  = lvl_w(L);
`ifdef POPCOUNT_ACCUM_EN
    localparam bit LAST_EN = 1'b1;
`else
    localparam bit LAST_EN = 1'b0;
`endif

    logic                   en;
    logic [PAD_W-1:0]       pad;
    logic [GROUPS-1:0][2:0] s0_cnt_d, s0_cnt_q;
    logic                   s0_vld_d, s0_vld_q;
    logic                   s0_last_d, s0_last_q;
    logic                   fin_vld, fin_last;
    logic [FIN_W-1:0]       fin_cnt;

    // One global advance: the whole pipe freezes while the output is stalled.
    assign en       = ~out_valid | out_ready;
    assign in_ready = en;
    assign pad      = PAD_W'(in_data);

    always_comb begin
        s0_vld_d  = en ? in_valid : s0_vld_q;
        s0_cnt_d  = s0_cnt_q;
        s0_last_d = s0_last_q;
        if (en & in_valid) begin
            for (int g = 0; g < GROUPS; g++)
                s0_cnt_d[g] = grp_cnt4(pad[4*g +: 4]);
            s0_last_d = LAST_EN & in_last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_vld_q  <= 1'b0;
            s0_cnt_q  <= '0;
            s0_last_q <= 1'b0;
        end else begin
            s0_vld_q  <= s0_vld_d;
            s0_cnt_q  <= s0_cnt_d;
            s0_last_q <= s0_last_d;
        end
    end

    if (L == 0) begin : g_flat
        assign fin_vld  = s0_vld_q;
        assign fin_cnt  = s0_cnt_q[0];
        assign fin_last = s0_last_q;
    end else begin : g_tree
        for (genvar l = 0; l < L; l++) begin : g_lvl
            localparam int N_IN  = lvl_n(GROUPS, l);
            localparam int IN_W  = lvl_w(l);
            localparam int N_OUT = (N_IN + 1) / 2;
            logic                      vi, li, vo, lo;
            logic [N_IN-1:0][IN_W-1:0] ci;
            logic [N_OUT-1:0][IN_W:0]  co;

            if (l == 0) begin : g_src
                assign vi = s0_vld_q;
                assign li = s0_last_q;
                assign ci = s0_cnt_q;
            end else begin : g_src
                assign vi = g_lvl[l-1].vo;
                assign li = g_lvl[l-1].lo;
                assign ci = g_lvl[l-1].co;
            end

            popcount_level #(.N_IN(N_IN), .IN_W(IN_W), .LAST_EN(LAST_EN)) u_lvl (
                .clk(clk), .rst_n(rst_n), .en(en),
                .in_vld(vi), .in_last(li), .in_cnt(ci),
                .out_vld(vo), .out_last(lo), .out_cnt(co)
            );
        end
        assign fin_vld  = g_lvl[L-1].vo;
        assign fin_last = g_lvl[L-1].lo;
        assign fin_cnt  = g_lvl[L-1].co[0];
    end

    assign out_valid = fin_vld;
    assign out_count = fin_vld ? CNT_W'(fin_cnt) : '0;

`ifdef POPCOUNT_ACCUM_EN
    logic             xfer;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] sat;
    logic [ACC_W-1:0] acc_d, acc_q, tot_d, tot_q;
    logic             accv_d, accv_q;

    always_comb begin
        xfer   = out_valid & out_ready;
        // A clear in the same cycle as a transfer restarts from this beat's count.
        sum    = (acc_clr ? '0 : {1'b0, acc_q}) + (ACC_W + 1)'(out_count);
        sat    = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
        acc_d  = acc_clr ? '0 : acc_q;
        tot_d  = tot_q;
        accv_d = 1'b0;
        if (xfer) begin
            acc_d = sat;
            if (fin_last) begin
                tot_d  = sat;
                accv_d = 1'b1;
                acc_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            tot_q  <= '0;
            accv_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            tot_q  <= tot_d;
            accv_q <= accv_d;
        end
    end

    assign acc_valid = accv_q;
    assign acc_total = tot_q;
`else
    logic unused_acc;
    assign unused_acc = acc_clr ^ fin_last;
    assign acc_valid  = 1'b0;
    assign acc_total  = '0;
`endif

endmodule

// File: tb/tb_popcount_pipe.sv
// Directed bench for popcount_pipe: streaming, backpressure, padded/tiny widths, reset, accumulator.
module tb_popcount_pipe;

    typedef struct {
        logic [15:0] data;
        logic        last;
        int          exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Main WIDTH=16 pipe and an ACC_W=5 twin sharing its inputs.
    logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1, acc_clr = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_ready, out_valid, acc_valid;
    logic [4:0]  out_count;
    logic [31:0] acc_total;
    logic        a5_in_ready, a5_out_valid, a5_acc_valid;
    logic [4:0]  a5_out_count, a5_acc_total;

    logic        w13_valid = 1'b0, w13_ready, w13_ov, w13_av;
    logic [12:0] w13_data = '0;
    logic [3:0]  w13_cnt;
    logic [31:0] w13_at;
    logic        w1_valid = 1'b0, w1_ready, w1_ov, w1_av;
    logic [0:0]  w1_data = '0, w1_cnt;
    logic [31:0] w1_at;

    popcount_pipe #(.WIDTH(16)) u_main (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count),
        .acc_clr(acc_clr), .acc_valid(acc_valid), .acc_total(acc_total));

    popcount_pipe #(.WIDTH(16), .ACC_W(5)) u_a5 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a5_in_ready), .in_data(in_data),
        .in_last(in_last), .out_valid(a5_out_valid), .out_ready(out_ready), .out_count(a5_out_count),
        .acc_clr(acc_clr), .acc_valid(a5_acc_valid), .acc_total(a5_acc_total));

    popcount_pipe #(.WIDTH(13)) u_w13 (
        .clk(clk), .rst_n(rst_n), .in_valid(w13_valid), .in_ready(w13_ready), .in_data(w13_data),
        .in_last(1'b0), .out_valid(w13_ov), .out_ready(1'b1), .out_count(w13_cnt),
        .acc_clr(1'b0), .acc_valid(w13_av), .acc_total(w13_at));

    popcount_pipe #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .in_valid(w1_valid), .in_ready(w1_ready), .in_data(w1_data),
        .in_last(1'b0), .out_valid(w1_ov), .out_ready(1'b1), .out_count(w1_cnt),
        .acc_clr(1'b0), .acc_valid(w1_av), .acc_total(w1_at));

    int   n_cmp = 0, n_err = 0;
    vec_t tbl[8];
    int   first_pop, last_pop, n_pops, m_pulses, a5_pulses;
    logic [31:0] m_total;
    logic [4:0]  a5_total;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Drive tbl[0..n-1] through the main pipe with an in-order scoreboard;
    // out_ready is low for cycles stall_lo..stall_hi, acc_clr pulses on cycle clr_cyc.
    task automatic run_stream(input int n, input int stall_lo, input int stall_hi,
                              input int stall_exp, input int clr_cyc);
        int q[$];
        int src = 0, idle = 0;
        first_pop = -1; last_pop = -1; n_pops = 0; m_pulses = 0; a5_pulses = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            in_valid  = (src < n);
            in_data   = (src < n) ? tbl[src].data : 16'h0;
            in_last   = (src < n) ? tbl[src].last : 1'b0;
            out_ready = !(c >= stall_lo && c <= stall_hi);
            acc_clr   = (c == clr_cyc);
            #1;
            if (c >= stall_lo && c <= stall_hi) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_hold", out_count, stall_exp);
                chk("stall_in_ready", in_ready, 0);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk("spurious_out", out_valid, 0);
                else begin
                    chk($sformatf("beat%0d", n_pops), out_count, q.pop_front());
                    if (first_pop < 0) first_pop = c;
                    last_pop = c;
                    n_pops++;
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(tbl[src].exp);
                src++;
            end
            if (acc_valid)    begin m_pulses++;  m_total  = acc_total;    end
            if (a5_acc_valid) begin a5_pulses++; a5_total = a5_acc_total; end
            if (src >= n && q.size() == 0) idle++;
            if (idle > 3) break;
        end
        chk("stream_drained", n_pops, n);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1; acc_clr = 1'b0;
    endtask

    task automatic single13(input logic [12:0] d, input int exp);
        int seen = -1;
        @(negedge clk); w13_valid = 1'b1; w13_data = d;
        for (int c = 1; c < 8; c++) begin
            @(negedge clk); w13_valid = 1'b0; w13_data = 13'h0AAA;
            #1;
            if (w13_ov && seen < 0) begin seen = c; chk("w13_count", w13_cnt, exp); end
        end
        chk("w13_latency", seen, 3);
    endtask

    task automatic single1(input logic d, input int exp);
        int seen = -1;
        @(negedge clk); w1_valid = 1'b1; w1_data = d;
        for (int c = 1; c < 6; c++) begin
            @(negedge clk); w1_valid = 1'b0; w1_data = ~d;
            #1;
            if (w1_ov && seen < 0) begin seen = c; chk("w1_count", w1_cnt, exp); end
        end
        chk("w1_latency", seen, 1);
    endtask

    initial begin
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_count", out_count, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_acc_valid", acc_valid, 0);
        chk("rst_acc_total", acc_total, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back stream, cycle-exact latency and continuity.
        tbl[0] = '{16'hFFFF, 1'b0, 16};
        tbl[1] = '{16'h0000, 1'b0, 0};
        tbl[2] = '{16'hA5A5, 1'b0, 8};
        tbl[3] = '{16'h000F, 1'b0, 4};
        tbl[4] = '{16'h8001, 1'b0, 2};
        tbl[5] = '{16'h7FFE, 1'b0, 14};
        tbl[6] = '{16'h1234, 1'b0, 5};
        tbl[7] = '{16'h00FF, 1'b0, 8};
        run_stream(8, -1, -2, 0, -1);
        chk("lat16_first", first_pop, 3);
        chk("continuous", last_pop - first_pop, 7);

        // Output stall with FFFF at the head; later beats must wait, not drop or repeat.
        tbl[0] = '{16'hFFFF, 1'b0, 16};
        tbl[1] = '{16'h0001, 1'b0, 1};
        tbl[2] = '{16'h0003, 1'b0, 2};
        tbl[3] = '{16'h0007, 1'b0, 3};
        tbl[4] = '{16'h000F, 1'b0, 4};
        run_stream(5, 3, 8, 16, -1);

        single13(13'h1FFF, 13);
        single13(13'h1000, 1);
        single13(13'h0000, 0);
        single1(1'b1, 1);
        single1(1'b0, 0);

        // Reset with beats in flight.
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            in_valid = (c < 3);
            in_data  = 16'h0F0F;
            #1;
        end
        chk("pre_reset_valid", out_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_count", out_count, 0);
        @(negedge clk); rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            chk("no_stale_result", out_valid, 0);
        end
        tbl[0] = '{16'h000F, 1'b0, 4};
        run_stream(1, -1, -2, 0, -1);
        chk("post_reset_lat", first_pop, 3);

        // Saturating frame sum, then clear coinciding with a transfer.
        tbl[0] = '{16'hFFFF, 1'b0, 16};
        tbl[1] = '{16'hFFFF, 1'b1, 16};
        run_stream(2, -1, -2, 0, -1);
`ifdef POPCOUNT_ACCUM_EN
        chk("a5_pulses", a5_pulses, 1);
        chk("a5_saturated", a5_total, 31);
`else
        chk("a5_no_pulse", a5_pulses, 0);
        chk("a5_total_tied", a5_acc_total, 0);
`endif
        tbl[0] = '{16'h0003, 1'b0, 2};
        tbl[1] = '{16'h0001, 1'b1, 1};
        run_stream(2, -1, -2, 0, 3);
`ifdef POPCOUNT_ACCUM_EN
        chk("clr_pulses", m_pulses, 1);
        chk("clr_total", m_total, 3);
        chk("clr_total_a5", a5_total, 3);
`else
        chk("main_no_pulse", m_pulses, 0);
        chk("main_total_tied", acc_total, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached, expected completion");
        $fatal(1);
    end

endmodule
